// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative radix-2 multiply / restoring divide unit that
// owns the HI/LO register pair. One shift-add or trial-subtract step per clock,
// then a single sign-fix cycle that writes HI/LO and pulses done.
// Build option: define MULDIV_DIVIDE_EN to include DIV/DIVU and divzero;
// without it divide requests are ignored and o_divzero is tied low.
//
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO accepted here
// S_RUN  | n iteration steps on the 2n-bit accumulator
// S_FIX  | apply signs, write HI/LO, pulse done
module muldiv_sequencer #(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [1:0]   i_op,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_mthi,
  input  logic         i_mtlo,
  input  logic [N-1:0] i_wdata,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_divzero,
  output logic [N-1:0] o_hi,
  output logic [N-1:0] o_lo
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_acc;
  logic [N-1:0]   r_opnd;
  logic           r_sign_a, r_sign_b;
  logic           r_busy, r_done;
  logic [N-1:0]   r_hi, r_lo;

  logic           w_div_ok, w_accept, w_b_zero;
  logic           w_neg_a, w_neg_b;
  logic [N-1:0]   w_mag_a, w_mag_b;
  logic [N:0]     w_sum;
  logic [2*N-1:0] w_mul_step, w_step, w_prod;
  logic [N-1:0]   w_fix_hi, w_fix_lo;

`ifdef MULDIV_DIVIDE_EN
  logic           r_is_div, r_dz, r_divzero;
  logic [N:0]     w_rem_sh;
  logic           w_ge;
  logic [N-1:0]   w_diff;
  logic [2*N-1:0] w_div_step;

  assign w_div_ok  = 1'b1;
  assign w_b_zero  = i_op[1] && (i_b == '0);
  assign o_divzero = r_divzero;

  // Restoring divide: shift {rem,quot} left, keep the difference if no borrow.
  assign w_rem_sh   = r_acc[2*N-1:N-1];
  assign w_ge       = (w_rem_sh >= {1'b0, r_opnd});
  assign w_diff     = r_acc[2*N-2:N-1] - r_opnd;
  assign w_div_step = {(w_ge ? w_diff : r_acc[2*N-2:N-1]), r_acc[N-2:0], w_ge};
  assign w_step     = r_is_div ? w_div_step : w_mul_step;
`else
  assign w_div_ok  = 1'b0;
  assign w_b_zero  = 1'b0;
  assign o_divzero = 1'b0;
  assign w_step    = w_mul_step;
`endif

  // Divide requests only count when the divide path is built in.
  assign w_accept = (r_state == S_IDLE) && i_start && (w_div_ok || !i_op[1]);

  // Magnitudes only for signed ops; unsigned operands pass straight through.
  assign w_neg_a = i_op[0] & i_a[N-1];
  assign w_neg_b = i_op[0] & i_b[N-1];
  assign w_mag_a = w_neg_a ? -i_a : i_a;
  assign w_mag_b = w_neg_b ? -i_b : i_b;

  // Shift-add multiply: carry out of the upper-half add shifts into the MSB.
  assign w_sum      = {1'b0, r_acc[2*N-1:N]} + {1'b0, r_opnd};
  assign w_mul_step = r_acc[0] ? {w_sum, r_acc[N-1:1]} : {1'b0, r_acc[2*N-1:1]};
  assign w_prod     = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_b_zero ? S_FIX : S_RUN;
      S_RUN:   if (r_cnt == CNT_LAST) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sign fix-up and HI/LO selection for the FIX cycle.
  always_comb begin
    w_fix_hi = w_prod[2*N-1:N];
    w_fix_lo = w_prod[N-1:0];
`ifdef MULDIV_DIVIDE_EN
    if (r_dz) begin
      w_fix_hi = r_acc[2*N-1:N];
      w_fix_lo = r_acc[N-1:0];
    end else if (r_is_div) begin
      w_fix_hi = r_sign_a ? -r_acc[2*N-1:N] : r_acc[2*N-1:N];
      w_fix_lo = (r_sign_a ^ r_sign_b) ? -r_acc[N-1:0] : r_acc[N-1:0];
    end
`endif
  end

  // Operand latch on accept, one iteration per RUN cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_sign_a <= w_neg_a;
      r_sign_b <= w_neg_b;
`ifdef MULDIV_DIVIDE_EN
      r_is_div <= i_op[1];
      r_dz     <= w_b_zero;
      if (w_b_zero) begin
        // Divide by zero: HI keeps the raw dividend, LO all ones.
        r_acc  <= {i_a, {N{1'b1}}};
        r_opnd <= '0;
      end else if (i_op[1]) begin
        r_acc  <= {{N{1'b0}}, w_mag_a};
        r_opnd <= w_mag_b;
      end else
`endif
      begin
        r_acc  <= {{N{1'b0}}, w_mag_b};
        r_opnd <= w_mag_a;
      end
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_step;
    end
  end

  // Registered status outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
      r_divzero <= 1'b0;
`endif
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (r_state == S_FIX);
`ifdef MULDIV_DIVIDE_EN
      r_divzero <= (r_state == S_FIX) && r_dz;
`endif
    end
  end

  // HI/LO: result write in FIX, MTHI/MTLO only in IDLE when no start is present.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_FIX) begin
      r_hi <= w_fix_hi;
      r_lo <= w_fix_lo;
    end else if ((r_state == S_IDLE) && !i_start) begin
      if (i_mthi) r_hi <= i_wdata;
      if (i_mtlo) r_lo <= i_wdata;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized and directed stimulus against an arithmetic
// reference model of MULT/MULTU/DIV/DIVU and MTHI/MTLO.
module tb_muldiv_sequencer;
  localparam int N = 32;

`ifdef MULDIV_DIVIDE_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start, mthi, mtlo;
  logic [1:0]   op;
  logic [N-1:0] a, b, wdata;
  logic         busy, done, divzero;
  logic [N-1:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;
  logic [N-1:0] m_hi = '0;
  logic [N-1:0] m_lo = '0;

  muldiv_sequencer #(.N(N)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_op(op),
    .i_a(a), .i_b(b), .i_mthi(mthi), .i_mtlo(mtlo), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_divzero(divzero), .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference result {HI,LO} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] va,
                                        input logic [31:0] vb);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(va));
    sb = longint'($signed(vb));
    res = '0;
    case (o)
      2'd0: res = {32'b0, va} * {32'b0, vb};
      2'd1: res = 64'(sa * sb);
      2'd2: res = (vb == 0) ? {va, 32'hFFFF_FFFF} : {va % vb, va / vb};
      default: begin
        if (vb == 0) res = {va, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Issue an op at the current negedge and follow it to completion.
  task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                        input bit poke);
    logic [63:0] r;
    bit acc, dz, seen;
    int lat, busy_n;
    r      = model(o, va, vb);
    acc    = !o[1] || DIV_EN;
    dz     = o[1] && (vb == 0);
    lat    = dz ? 2 : N + 2;
    busy_n = 0;
    seen   = 1'b0;
    op = o; a = va; b = vb; start = 1'b1;
    if (acc) begin
      for (int k = 1; k <= N + 8 && !seen; k++) begin
        @(negedge clk);
        if (done) begin
          seen = 1'b1;
          chk("latency", 64'(k), 64'(lat));
          chk("busy_at_done", 64'(busy), 64'd0);
          chk("divzero", 64'(divzero), 64'(dz));
          chk("hi", 64'(hi), 64'(r[63:32]));
          chk("lo", 64'(lo), 64'(r[31:0]));
          m_hi = r[63:32];
          m_lo = r[31:0];
        end else begin
          if (busy) busy_n++;
          if (k == 1 || k == 6) begin
            chk("hold_hi", 64'(hi), 64'(m_hi));
            chk("hold_lo", 64'(lo), 64'(m_lo));
          end
          start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
          a = $urandom; b = $urandom; op = 2'($urandom);
          if (poke && k == 5) begin
            start = 1'b1; mthi = 1'b1; wdata = 32'h55;
          end
        end
      end
      if (!seen) chk("done_timeout", 64'd0, 64'd1);
      else       chk("busy_cycles", 64'(busy_n), 64'(lat - 1));
    end else begin
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        chk("ignored_busy", 64'(busy), 64'd0);
        chk("ignored_done", 64'(done), 64'd0);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      chk("ignored_hi", 64'(hi), 64'(m_hi));
      chk("ignored_lo", 64'(lo), 64'(m_lo));
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    bit          mh, ml;
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = '0; a = '0; b = '0; wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_divzero", 64'(divzero), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'd2, 32'd100, 32'd0, 1'b0);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);

    // Reset in the middle of RUN discards the operation.
    @(negedge clk);
    op = 2'd0; a = 32'd7; b = 32'd6; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_hi", 64'(hi), 64'd0);
    chk("mid_rst_lo", 64'(lo), 64'd0);
    m_hi = '0; m_lo = '0;
    run_op(2'd0, 32'd7, 32'd6, 1'b0);

    // start + mthi while busy are dropped.
    run_op(2'd1, 32'h0001_2345, 32'hFFFF_FF00, 1'b1);

    // MTHI alone, then MTHI+MTLO together, in IDLE.
    @(negedge clk);
    mthi = 1'b1; wdata = 32'h55;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h55);
    chk("mthi_lo", 64'(lo), 64'(m_lo));
    m_hi = 32'h55;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_0F0F;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mtboth_hi", 64'(hi), 64'hA5A5_0F0F);
    chk("mtboth_lo", 64'(lo), 64'hA5A5_0F0F);
    m_hi = 32'hA5A5_0F0F; m_lo = 32'hA5A5_0F0F;

    // start and mtlo together: the product wins.
    mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
    run_op(2'd0, 32'd3, 32'd9, 1'b0);

    // Random back-to-back ops with occasional idle moves.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        mh = 1'($urandom); ml = 1'($urandom);
        mthi = mh; mtlo = ml; wdata = $urandom;
        if (mh) m_hi = wdata;
        if (ml) m_lo = wdata;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        chk("rnd_mt_hi", 64'(hi), 64'(m_hi));
        chk("rnd_mt_lo", 64'(lo), 64'(m_lo));
      end
      run_op(ro, ra, rb, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
